release_lock_arbiter: RTL and testbench

- 4-input locking round-robin arbiter for the release/voluntary-writeback network feeding the 4-port bus crossbar.
- Selects one requester per message; multi-beat data messages hold the grant until their last beat transfers.
- Provides the chosen index and a lock-stall watchdog flag.
- Sits between client release queues and the destination-routing stage; the crossbar's per-destination ready mux drives out_ready.

---
 rtl/release_lock_arbiter_pkg.sv | 41 ++++
 rtl/release_lock_arbiter_rr_pick4.sv | 26 ++
 rtl/release_lock_arbiter.sv | 122 ++++++++++++
 tb/tb_release_lock_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/release_lock_arbiter_pkg.sv
// Shared message layout, release type encodings and helpers for the release lock arbiter.
package release_lock_arbiter_pkg;

  // Network geometry: four requesters, 102-bit packed release message.
  localparam int N_IN    = 4;
  localparam int MSG_W   = 102;
  localparam int IDX_W   = 2;

  // Field positions inside the packed message (MSB to LSB:
  // src 2, dst 2, addr_beat 3, addr_block 26, xact_id 1, voluntary 1, r_type 3, data 64).
  localparam int DATA_W    = 64;
  localparam int RTYPE_LSB = 64;
  localparam int RTYPE_W   = 3;
  localparam int BEAT_LSB  = 95;
  localparam int BEAT_W    = 3;
  localparam int DST_LSB   = 98;

  // A data-carrying release occupies one refill's worth of beats.
  localparam int BEATS_DEFAULT     = 8;
  localparam int STALL_MAX_DEFAULT = 255;

  // Release message types; the first three carry a data payload.
  localparam logic [RTYPE_W-1:0] RT_RELEASE_INVALIDATE_DATA = 3'd0;
  localparam logic [RTYPE_W-1:0] RT_RELEASE_DOWNGRADE_DATA  = 3'd1;
  localparam logic [RTYPE_W-1:0] RT_RELEASE_COPY_DATA       = 3'd2;
  localparam logic [RTYPE_W-1:0] RT_RELEASE_INVALIDATE_ACK  = 3'd3;

  typedef enum logic {
    LOCK_UNLOCKED = 1'b0,
    LOCK_LOCKED   = 1'b1
  } lock_st_e;

  // True when the message type spans multiple beats and must hold the grant.
  function automatic logic has_data(input logic [RTYPE_W-1:0] r_type, input int beats);
    return (beats > 1) &&
           ((r_type == RT_RELEASE_INVALIDATE_DATA) ||
            (r_type == RT_RELEASE_DOWNGRADE_DATA)  ||
            (r_type == RT_RELEASE_COPY_DATA));
  endfunction

endpackage

// File: rtl/release_lock_arbiter_rr_pick4.sv
// Combinational 4-way rotating-priority picker: the requester right after
// 'last' has highest priority, 'last' itself has lowest.
module rr_pick4 (
  input  logic [3:0] valid,
  input  logic [1:0] last,
  output logic [1:0] grant,
  output logic       any
);

  logic [1:0] cand;

  // Scan from lowest to highest priority so the highest-priority hit wins.
  always_comb begin
    grant = 2'd0;
    any   = 1'b0;
    cand  = last;
    for (int k = 4; k >= 1; k--) begin
      cand = last + k[1:0];
      if (valid[cand]) begin
        grant = cand;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/release_lock_arbiter.sv
// Locking round-robin arbiter for the release/voluntary-writeback network.
// Multi-beat data releases keep the grant until their final beat transfers.
module release_lock_arbiter
  import release_lock_arbiter_pkg::*;
#(
  parameter int BEATS     = BEATS_DEFAULT,
  parameter int STALL_MAX = STALL_MAX_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_IN-1:0]        in_valid,
  output logic [N_IN-1:0]        in_ready,
  input  logic [N_IN*MSG_W-1:0]  in_bits,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [MSG_W-1:0]       out_bits,
  output logic [IDX_W-1:0]       out_chosen,
  output logic                   locked,
  output logic                   stall_err
);

  localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SCNT_W = $clog2(STALL_MAX + 1);
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);
  localparam logic [SCNT_W-1:0] STALL_LIM = SCNT_W'(STALL_MAX);

  lock_st_e           lock_st_q,   lock_st_d;
  logic [IDX_W-1:0]   lock_idx_q,  lock_idx_d;
  logic [BCNT_W-1:0]  beat_cnt_q,  beat_cnt_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [SCNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic               stall_err_q, stall_err_d;

  logic [MSG_W-1:0]   msg [N_IN];
  logic [IDX_W-1:0]   pick_grant;
  logic               pick_any;
  logic               is_locked;
  logic [IDX_W-1:0]   sel_idx;
  logic               fire;

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_unpack
    assign msg[gi] = in_bits[gi*MSG_W +: MSG_W];
  end

  rr_pick4 u_pick (
    .valid (in_valid),
    .last  (last_grant_q),
    .grant (pick_grant),
    .any   (pick_any)
  );

  // While locked the lock owner is the only candidate; otherwise the picker decides.
  // The picker reports index 0 when nothing is requesting, so sel_idx doubles as out_chosen.
  assign is_locked  = (lock_st_q == LOCK_LOCKED);
  assign sel_idx    = is_locked ? lock_idx_q : pick_grant;
  assign out_chosen = sel_idx;
  assign out_bits   = msg[sel_idx];
  assign out_valid  = is_locked ? in_valid[lock_idx_q] : pick_any;
  assign fire       = out_valid & out_ready;
  assign locked     = is_locked;
  assign stall_err  = stall_err_q;

  // Ready follows the grant only, never the requester's own valid.
  for (genvar gi = 0; gi < N_IN; gi++) begin : g_ready
    assign in_ready[gi] = out_ready & (sel_idx == IDX_W'(gi));
  end

  // Next-state: lock FSM, beat counter, round-robin pointer and stall watchdog.
  always_comb begin
    lock_st_d    = lock_st_q;
    lock_idx_d   = lock_idx_q;
    beat_cnt_d   = beat_cnt_q;
    last_grant_d = last_grant_q;
    stall_cnt_d  = stall_cnt_q;
    stall_err_d  = stall_err_q;

    if (fire) begin
      if (!is_locked) begin
        // Only a first beat advances the round-robin pointer.
        last_grant_d = pick_grant;
        if (has_data(out_bits[RTYPE_LSB +: RTYPE_W], BEATS)) begin
          lock_st_d  = LOCK_LOCKED;
          lock_idx_d = pick_grant;
          beat_cnt_d = BCNT_W'(1);
        end
      end else if (beat_cnt_q == LAST_BEAT) begin
        lock_st_d  = LOCK_UNLOCKED;
        beat_cnt_d = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + BCNT_W'(1);
      end
    end

    // Count locked cycles with no transfer; saturate so the flag cannot wrap away.
    if (is_locked && !fire) begin
      stall_cnt_d = (stall_cnt_q == STALL_LIM) ? stall_cnt_q : stall_cnt_q + SCNT_W'(1);
    end else begin
      stall_cnt_d = '0;
    end
    stall_err_d = stall_err_q | (stall_cnt_d == STALL_LIM);
  end

  // State registers; reset abandons any message in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lock_st_q    <= LOCK_UNLOCKED;
      lock_idx_q   <= '0;
      beat_cnt_q   <= '0;
      last_grant_q <= IDX_W'(3);
      stall_cnt_q  <= '0;
      stall_err_q  <= 1'b0;
    end else begin
      lock_st_q    <= lock_st_d;
      lock_idx_q   <= lock_idx_d;
      beat_cnt_q   <= beat_cnt_d;
      last_grant_q <= last_grant_d;
      stall_cnt_q  <= stall_cnt_d;
      stall_err_q  <= stall_err_d;
    end
  end

endmodule

// File: tb/tb_release_lock_arbiter.sv
// Scoreboard bench for release_lock_arbiter: expected per-cycle grant state is
// queued as stimulus is applied and checked when the DUT outputs settle.
module tb_release_lock_arbiter;
  import release_lock_arbiter_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [3:0]            in_valid = '0;
  logic [3:0]            in_ready;
  logic [4*MSG_W-1:0]    in_bits = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [MSG_W-1:0]      out_bits;
  logic [1:0]            out_chosen;
  logic                  locked;
  logic                  stall_err;

  release_lock_arbiter #(.BEATS(8), .STALL_MAX(255)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bits    (in_bits),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bits   (out_bits),
    .out_chosen (out_chosen),
    .locked     (locked),
    .stall_err  (stall_err)
  );

  always #5 clk = ~clk;

  // flags = {out_valid, out_chosen, in_ready, locked}
  typedef struct packed {
    logic [7:0]       flags;
    logic [MSG_W-1:0] bits;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             e;
  logic [MSG_W-1:0] msg [4];
  int               n_cmp = 0;
  int               n_bad = 0;

  function automatic logic [MSG_W-1:0] mk(input logic [1:0] src, input logic [2:0] rt,
                                          input logic [63:0] data);
    return {src, 2'd1, 3'd0, 26'h0, 1'b0, 1'b1, rt, data};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [3:0] v, input logic rdy);
    in_valid  = v;
    out_ready = rdy;
    for (int i = 0; i < 4; i++) in_bits[i*MSG_W +: MSG_W] = msg[i];
  endtask

  task automatic push_exp(input logic vld, input logic [1:0] ch, input logic [3:0] rdy,
                          input logic lk);
    exp_t x;
    x.flags = {vld, ch, rdy, lk};
    x.bits  = msg[ch];
    exp_q.push_back(x);
  endtask

  task automatic test_reset();
    apply(4'b0000, 1'b1);
    @(negedge clk);
    n_cmp++;
    if ({locked, stall_err} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_status: locked/stall_err=%b want 00", {locked, stall_err});
    end
    n_cmp++;
    if ({out_valid, out_chosen} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_idle: valid/chosen=%b want 000", {out_valid, out_chosen});
    end
    $display("txn reset: locked=%b stall_err=%b out_valid=%b", locked, stall_err, out_valid);
    tick();
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 4; i++) msg[i] = mk(i[1:0], 3'd3, 64'hA0 + 64'(i));
    for (int c = 0; c < 4; c++) begin
      apply(4'b1111, 1'b1);
      push_exp(1'b1, c[1:0], 4'b0001 << c, 1'b0);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if ({out_valid, out_chosen, in_ready, locked} !== e.flags || out_bits !== e.bits) begin
        n_bad++;
        $display("FAIL round_robin c%0d: got v/ch/rdy/lk=%b bits=%h want %b bits=%h",
                 c, {out_valid, out_chosen, in_ready, locked}, out_bits, e.flags, e.bits);
      end
      $display("txn round_robin c%0d: chosen=%0d locked=%b", c, out_chosen, locked);
      tick();
    end
  endtask

  task automatic test_data_lock();
    msg[1] = mk(2'd1, 3'd0, 64'hD1D1_0000);
    msg[2] = mk(2'd2, 3'd3, 64'h2222);
    for (int c = 0; c < 9; c++) begin
      apply(4'b0110, 1'b1);
      if (c < 8) push_exp(1'b1, 2'd1, 4'b0010, (c > 0));
      else       push_exp(1'b1, 2'd2, 4'b0100, 1'b0);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if ({out_valid, out_chosen, in_ready, locked} !== e.flags || out_bits !== e.bits) begin
        n_bad++;
        $display("FAIL data_lock c%0d: got v/ch/rdy/lk=%b bits=%h want %b bits=%h",
                 c, {out_valid, out_chosen, in_ready, locked}, out_bits, e.flags, e.bits);
      end
      $display("txn data_lock c%0d: chosen=%0d locked=%b", c, out_chosen, locked);
      tick();
    end
    apply(4'b0000, 1'b1);
  endtask

  // Lock on req 0, three beats, then 5 cycles of backpressure, then 5 remaining beats.
  task automatic test_lock_hold();
    msg[0] = mk(2'd0, 3'd1, 64'h0D0D);
    msg[1] = mk(2'd1, 3'd3, 64'h1111);
    msg[2] = mk(2'd2, 3'd3, 64'h2222);
    msg[3] = mk(2'd3, 3'd3, 64'h3333);
    for (int c = 0; c < 14; c++) begin
      if (c < 3) begin
        apply(4'b0001, 1'b1); push_exp(1'b1, 2'd0, 4'b0001, (c > 0));
      end else if (c < 8) begin
        apply(4'b1111, 1'b0); push_exp(1'b1, 2'd0, 4'b0000, 1'b1);
      end else if (c < 13) begin
        apply(4'b1111, 1'b1); push_exp(1'b1, 2'd0, 4'b0001, 1'b1);
      end else begin
        apply(4'b1111, 1'b1); push_exp(1'b1, 2'd1, 4'b0010, 1'b0);
      end
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if ({out_valid, out_chosen, in_ready, locked} !== e.flags || out_bits !== e.bits) begin
        n_bad++;
        $display("FAIL lock_hold c%0d: got v/ch/rdy/lk=%b bits=%h want %b bits=%h",
                 c, {out_valid, out_chosen, in_ready, locked}, out_bits, e.flags, e.bits);
      end
      $display("txn lock_hold c%0d: chosen=%0d locked=%b", c, out_chosen, locked);
      tick();
    end
    apply(4'b0000, 1'b1);
  endtask

  // Lock on req 3, owner drops valid for 2 cycles, then 5 remaining beats, then req 0.
  task automatic test_valid_drop();
    msg[3] = mk(2'd3, 3'd2, 64'h3D3D);
    msg[0] = mk(2'd0, 3'd3, 64'h0A0A);
    for (int c = 0; c < 11; c++) begin
      if (c < 3) begin
        apply(4'b1000, 1'b1); push_exp(1'b1, 2'd3, 4'b1000, (c > 0));
      end else if (c < 5) begin
        apply(4'b0001, 1'b1); push_exp(1'b0, 2'd3, 4'b1000, 1'b1);
      end else if (c < 10) begin
        apply(4'b1001, 1'b1); push_exp(1'b1, 2'd3, 4'b1000, 1'b1);
      end else begin
        apply(4'b1001, 1'b1); push_exp(1'b1, 2'd0, 4'b0001, 1'b0);
      end
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if ({out_valid, out_chosen, in_ready, locked} !== e.flags || out_bits !== e.bits) begin
        n_bad++;
        $display("FAIL valid_drop c%0d: got v/ch/rdy/lk=%b bits=%h want %b bits=%h",
                 c, {out_valid, out_chosen, in_ready, locked}, out_bits, e.flags, e.bits);
      end
      $display("txn valid_drop c%0d: chosen=%0d valid=%b locked=%b", c, out_chosen,
               out_valid, locked);
      tick();
    end
    apply(4'b0000, 1'b1);
  endtask

  task automatic test_stall_watchdog();
    msg[1] = mk(2'd1, 3'd0, 64'h5757);
    apply(4'b0010, 1'b1);
    push_exp(1'b1, 2'd1, 4'b0010, 1'b0);
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if ({out_valid, out_chosen, in_ready, locked} !== e.flags || out_bits !== e.bits) begin
      n_bad++;
      $display("FAIL stall_first: got v/ch/rdy/lk=%b want %b",
               {out_valid, out_chosen, in_ready, locked}, e.flags);
    end
    tick();
    apply(4'b0010, 1'b0);
    for (int s = 1; s <= 255; s++) begin
      tick();
      if (s == 254) begin
        n_cmp++;
        if (stall_err !== 1'b0) begin
          n_bad++;
          $display("FAIL stall_254: stall_err=%b want 0", stall_err);
        end
      end
      if (s == 255) begin
        n_cmp++;
        if (stall_err !== 1'b1) begin
          n_bad++;
          $display("FAIL stall_255: stall_err=%b want 1", stall_err);
        end
        $display("txn stall: after %0d stalled cycles stall_err=%b", s, stall_err);
      end
    end
    for (int c = 0; c < 7; c++) begin
      apply(4'b0010, 1'b1);
      push_exp(1'b1, 2'd1, 4'b0010, 1'b1);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if ({out_valid, out_chosen, in_ready, locked} !== e.flags || stall_err !== 1'b1) begin
        n_bad++;
        $display("FAIL stall_resume c%0d: got v/ch/rdy/lk=%b err=%b want %b err=1",
                 c, {out_valid, out_chosen, in_ready, locked}, stall_err, e.flags);
      end
      $display("txn stall_resume c%0d: chosen=%0d stall_err=%b", c, out_chosen, stall_err);
      tick();
    end
    apply(4'b0000, 1'b1);
    @(negedge clk);
    n_cmp++;
    if ({locked, stall_err} !== 2'b01) begin
      n_bad++;
      $display("FAIL stall_sticky: locked/stall_err=%b want 01", {locked, stall_err});
    end
    tick();
  endtask

  task automatic test_reset_mid_lock();
    msg[2] = mk(2'd2, 3'd0, 64'h2D2D);
    msg[0] = mk(2'd0, 3'd3, 64'h0B0B);
    msg[1] = mk(2'd1, 3'd3, 64'h1B1B);
    msg[3] = mk(2'd3, 3'd3, 64'h3B3B);
    for (int c = 0; c < 4; c++) begin
      apply(4'b0100, 1'b1);
      push_exp(1'b1, 2'd2, 4'b0100, (c > 0));
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if ({out_valid, out_chosen, in_ready, locked} !== e.flags || out_bits !== e.bits) begin
        n_bad++;
        $display("FAIL mid_lock c%0d: got v/ch/rdy/lk=%b want %b",
                 c, {out_valid, out_chosen, in_ready, locked}, e.flags);
      end
      tick();
    end
    apply(4'b1111, 1'b1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      push_exp(1'b1, c[1:0], 4'b0001 << c, 1'b0);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if ({out_valid, out_chosen, in_ready, locked} !== e.flags || out_bits !== e.bits ||
          stall_err !== 1'b0) begin
        n_bad++;
        $display("FAIL after_reset c%0d: got v/ch/rdy/lk=%b err=%b want %b err=0",
                 c, {out_valid, out_chosen, in_ready, locked}, stall_err, e.flags);
      end
      $display("txn after_reset c%0d: chosen=%0d locked=%b", c, out_chosen, locked);
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) msg[i] = '0;
    reset = 1'b0;
    apply(4'b0000, 1'b1);
    tick();
    tick();
    reset = 1'b1;
    test_reset();
    test_round_robin();
    test_data_lock();
    test_lock_hold();
    test_valid_drop();
    test_stall_watchdog();
    test_reset_mid_lock();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
